multicycle_controller: RTL and testbench

//  Moore/Mealy FSM that sequences the multi-cycle RV32I datapath: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.

---
 rtl/rv_ctrl_pkg.sv | 60 ++++++
 rtl/mc_wait_timer.sv | 36 +++
 rtl/multicycle_controller.sv | 177 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states, instruction classes, pcSrc/aluOp codes.
// The HALT state exists only when ILLEGAL_TRAP_EN is defined.
package rv_ctrl_pkg;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpLd   = 7'b0000011;
    localparam logic [6:0] OpSt   = 7'b0100011;
    localparam logic [6:0] OpBr   = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StFault
`ifdef ILLEGAL_TRAP_EN
        ,
        StHalt
`endif
    } state_e;

    typedef enum logic [2:0] {
        ClsR,
        ClsI,
        ClsLd,
        ClsSt,
        ClsBr,
        ClsJal,
        ClsJalr,
        ClsBad
    } class_e;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJal    = 2'b10;
    localparam logic [1:0] PcJalr   = 2'b11;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluCmp   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    function automatic class_e decode_class(input logic [6:0] op);
        case (op)
            OpR:     return ClsR;
            OpI:     return ClsI;
            OpLd:    return ClsLd;
            OpSt:    return ClsSt;
            OpBr:    return ClsBr;
            OpJal:   return ClsJal;
            OpJalr:  return ClsJalr;
            default: return ClsBad;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts cycles while enabled, flags expiry on the last allowed wait cycle.
// MEM_TIMEOUT = 0 disables expiry.
module mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_watchdog
            assign expire = 1'b0;
        end else begin : g_watchdog
            localparam logic [CNT_W-1:0] Last = CNT_W'(MEM_TIMEOUT - 1);
            // Expire only when still waiting in the last allowed cycle; ready in that cycle wins.
            assign expire = en && (cnt == Last);
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory watchdog and FAULT trap.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT instead of retiring them as NOPs.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branchTaken,
    input  logic       imemReady,
    input  logic       dmemReady,
    output logic       imemReq,
    output logic       dmemReq,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic [1:0] aluOp,
    output logic       aluSrc,
    output logic       regWrite,
    output logic       memToReg,
    output logic       instRetired,
    output logic       busFault,
    output logic       illegalInst
);

    state_e state;
    class_e cls;
    class_e dec_cls;
    logic   bus_fault;
    logic   waiting;
    logic   expire;

    assign dec_cls = decode_class(opcode);

    always_comb begin
        waiting = 1'b0;
        if (state == StFetch) begin
            waiting = !imemReady;
        end else if (state == StMem) begin
            waiting = !dmemReady;
        end
    end

    // Counter runs only across consecutive wait cycles, so it is zero on every FETCH/MEM entry.
    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!waiting),
        .en    (waiting),
        .expire(expire)
    );

`ifdef ILLEGAL_TRAP_EN
    logic illegal_flag;
    assign illegalInst = illegal_flag;
`else
    assign illegalInst = 1'b0;
`endif
    assign busFault = bus_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cls       <= ClsR;
            bus_fault <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_flag <= 1'b0;
`endif
        end else if (expire) begin
            state     <= StFault;
            bus_fault <= 1'b1;
        end else begin
            case (state)
                StIdle:   state <= StFetch;
                StFetch:  if (imemReady) state <= StDecode;
                StDecode: begin
                    cls <= dec_cls;
                    if (dec_cls == ClsBad) begin
`ifdef ILLEGAL_TRAP_EN
                        state        <= StHalt;
                        illegal_flag <= 1'b1;
`else
                        state <= StFetch;
`endif
                    end else begin
                        state <= StExec;
                    end
                end
                StExec: begin
                    case (cls)
                        ClsR, ClsI:   state <= StWb;
                        ClsLd, ClsSt: state <= StMem;
                        default:      state <= StFetch;
                    endcase
                end
                StMem:    if (dmemReady) state <= (cls == ClsLd) ? StWb : StFetch;
                StWb:     state <= StFetch;
                default:  state <= state;
            endcase
        end
    end

    always_comb begin
        imemReq     = 1'b0;
        dmemReq     = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        pcSrc       = PcPlus4;
        aluOp       = AluAdd;
        aluSrc      = 1'b0;
        regWrite    = 1'b0;
        memToReg    = 1'b0;
        instRetired = 1'b0;
        case (state)
            StFetch: begin
                imemReq = 1'b1;
                irWrite = imemReady;
                pcWrite = imemReady;
            end
            StDecode: begin
`ifndef ILLEGAL_TRAP_EN
                instRetired = (dec_cls == ClsBad);
`endif
            end
            StExec: begin
                case (cls)
                    ClsR:               aluOp = AluFunct;
                    ClsI, ClsLd, ClsSt: aluSrc = 1'b1;
                    ClsBr: begin
                        aluOp       = AluCmp;
                        pcWrite     = branchTaken;
                        pcSrc       = PcBranch;
                        instRetired = 1'b1;
                    end
                    ClsJal: begin
                        regWrite    = 1'b1;
                        pcWrite     = 1'b1;
                        pcSrc       = PcJal;
                        instRetired = 1'b1;
                    end
                    ClsJalr: begin
                        aluSrc      = 1'b1;
                        regWrite    = 1'b1;
                        pcWrite     = 1'b1;
                        pcSrc       = PcJalr;
                        instRetired = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                dmemReq     = 1'b1;
                memRead     = (cls == ClsLd);
                memWrite    = (cls == ClsSt);
                aluSrc      = 1'b1;
                instRetired = dmemReady && (cls == ClsSt);
            end
            StWb: begin
                regWrite    = 1'b1;
                memToReg    = (cls == ClsLd);
                instRetired = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; all outputs packed and compared per cycle.
// Honours ILLEGAL_TRAP_EN for the unknown-opcode step.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branchTaken, imemReady, dmemReady;
    logic       imemReq, dmemReq, memRead, memWrite, irWrite, pcWrite;
    logic [1:0] pcSrc, aluOp;
    logic       aluSrc, regWrite, memToReg, instRetired, busFault, illegalInst;

    int passed = 0;
    int total  = 0;

    // Packed order: imemReq dmemReq memRead memWrite irWrite pcWrite pcSrc[2] aluOp[2]
    //               aluSrc regWrite memToReg instRetired busFault illegalInst
    localparam logic [15:0] EIdle    = 16'h0000;
    localparam logic [15:0] EFetchW  = 16'h8000;
    localparam logic [15:0] EFetch   = 16'h8C00;
    localparam logic [15:0] EDecode  = 16'h0000;
    localparam logic [15:0] ENop     = 16'h0004;
    localparam logic [15:0] EExImm   = 16'h0020;
    localparam logic [15:0] EExR     = 16'h0080;
    localparam logic [15:0] EExBrT   = 16'h0544;
    localparam logic [15:0] EExBrN   = 16'h0144;
    localparam logic [15:0] EExJal   = 16'h0614;
    localparam logic [15:0] EWbAlu   = 16'h0014;
    localparam logic [15:0] EWbLd    = 16'h001C;
    localparam logic [15:0] EMemLd   = 16'h6020;
    localparam logic [15:0] EMemStW  = 16'h5020;
    localparam logic [15:0] EMemStD  = 16'h5024;
    localparam logic [15:0] EFault   = 16'h0002;
    localparam logic [15:0] EHalt    = 16'h0001;

    multicycle_controller #(
        .MEM_TIMEOUT(16),
        .CNT_W      (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .branchTaken(branchTaken),
        .imemReady  (imemReady),
        .dmemReady  (dmemReady),
        .imemReq    (imemReq),
        .dmemReq    (dmemReq),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .pcWrite    (pcWrite),
        .pcSrc      (pcSrc),
        .aluOp      (aluOp),
        .aluSrc     (aluSrc),
        .regWrite   (regWrite),
        .memToReg   (memToReg),
        .instRetired(instRetired),
        .busFault   (busFault),
        .illegalInst(illegalInst)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        #2;
        obs = {imemReq, dmemReq, memRead, memWrite, irWrite, pcWrite, pcSrc, aluOp,
               aluSrc, regWrite, memToReg, instRetired, busFault, illegalInst};
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // FETCH with ready high, then leave the cycle with ready low again.
    task automatic do_fetch(input string tag, input logic [6:0] op);
        opcode    = op;
        imemReady = 1'b1;
        chk(tag, EFetch);
        nxt();
        imemReady = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        opcode      = 7'b0;
        branchTaken = 1'b0;
        imemReady   = 1'b0;
        dmemReady   = 1'b0;
        chk("reset", EIdle);
        nxt();
        rst_n = 1'b1;
        chk("idle", EIdle);
        nxt();
        chk("fetch_wait0", EFetchW);
        nxt();
        chk("fetch_wait1", EFetchW);
        nxt();

        // Two back-to-back addi: retire every fourth cycle.
        for (int k = 0; k < 2; k++) begin
            do_fetch("addi_fetch", 7'b0010011);
            chk("addi_decode", EDecode);
            nxt();
            chk("addi_exec", EExImm);
            nxt();
            chk("addi_wb", EWbAlu);
            nxt();
        end

        // lw with dmemReady three cycles late.
        do_fetch("lw_fetch", 7'b0000011);
        chk("lw_decode", EDecode);
        nxt();
        chk("lw_exec", EExImm);
        nxt();
        for (int k = 0; k < 3; k++) begin
            chk("lw_mem_wait", EMemLd);
            nxt();
        end
        dmemReady = 1'b1;
        chk("lw_mem_done", EMemLd);
        nxt();
        dmemReady = 1'b0;
        chk("lw_wb", EWbLd);
        nxt();

        // beq taken, then not taken; both return straight to FETCH.
        do_fetch("beq_t_fetch", 7'b1100011);
        chk("beq_t_decode", EDecode);
        nxt();
        branchTaken = 1'b1;
        chk("beq_t_exec", EExBrT);
        nxt();
        branchTaken = 1'b0;
        do_fetch("beq_n_fetch", 7'b1100011);
        chk("beq_n_decode", EDecode);
        nxt();
        chk("beq_n_exec", EExBrN);
        nxt();

        // R-type and JAL.
        do_fetch("add_fetch", 7'b0110011);
        nxt();
        chk("add_exec", EExR);
        nxt();
        chk("add_wb", EWbAlu);
        nxt();
        do_fetch("jal_fetch", 7'b1101111);
        nxt();
        chk("jal_exec", EExJal);
        nxt();

        // sw whose ready lands in the last allowed wait cycle still completes.
        do_fetch("sw_edge_fetch", 7'b0100011);
        nxt();
        chk("sw_edge_exec", EExImm);
        nxt();
        for (int k = 0; k < 15; k++) begin
            chk("sw_edge_wait", EMemStW);
            nxt();
        end
        dmemReady = 1'b1;
        chk("sw_edge_done", EMemStD);
        nxt();
        dmemReady = 1'b0;

        // Unknown opcode.
        do_fetch("ill_fetch", 7'b0000000);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_decode", EDecode);
        nxt();
        chk("ill_halt0", EHalt);
        nxt();
        imemReady = 1'b1;
        chk("ill_halt1", EHalt);
        rst_n = 1'b0;
        chk("ill_reset", EIdle);
        nxt();
        rst_n     = 1'b1;
        imemReady = 1'b0;
        nxt();
`else
        chk("nop_decode", ENop);
        nxt();
`endif

        // sw with dmemReady never: FAULT after 16 MEM cycles, sticky until reset.
        do_fetch("sw_to_fetch", 7'b0100011);
        nxt();
        chk("sw_to_exec", EExImm);
        nxt();
        for (int k = 0; k < 16; k++) begin
            chk("sw_to_wait", EMemStW);
            nxt();
        end
        imemReady = 1'b1;
        dmemReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("fault_sticky", EFault);
            nxt();
        end
        rst_n = 1'b0;
        chk("fault_reset", EIdle);
        nxt();
        rst_n     = 1'b1;
        imemReady = 1'b0;
        dmemReady = 1'b0;
        chk("fault_idle", EIdle);
        nxt();
        chk("fault_refetch", EFetchW);
        nxt();

        // Reset asserted during MEM of sw.
        do_fetch("swr_fetch", 7'b0100011);
        nxt();
        nxt();
        chk("swr_mem", EMemStW);
        rst_n = 1'b0;
        chk("swr_async", EIdle);
        nxt();
        chk("swr_held", EIdle);
        rst_n = 1'b1;
        chk("swr_idle", EIdle);
        nxt();
        chk("swr_fetch0", EFetchW);
        nxt();
        chk("swr_fetch1", EFetchW);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
